// File: rtl/seq_alu_pkg.sv
// Shared aluop encodings and opcode classification helpers for the sequential ALU.
package seq_alu_pkg;

    localparam int ALUOP_W = 4;
    typedef logic [ALUOP_W-1:0] aluop_t;

    localparam aluop_t OP_ADD   = 4'd0;
    localparam aluop_t OP_SUB   = 4'd1;
    localparam aluop_t OP_AND   = 4'd2;
    localparam aluop_t OP_OR    = 4'd3;
    localparam aluop_t OP_SLT   = 4'd4;
    localparam aluop_t OP_LUI   = 4'd5;
    localparam aluop_t OP_EQB   = 4'd6;
    localparam aluop_t OP_MULT  = 4'd7;
    localparam aluop_t OP_MULTU = 4'd8;
    localparam aluop_t OP_DIV   = 4'd9;
    localparam aluop_t OP_DIVU  = 4'd10;
    localparam aluop_t OP_MFHI  = 4'd11;
    localparam aluop_t OP_MFLO  = 4'd12;
    localparam aluop_t OP_MAX   = OP_MFLO;

    function automatic logic op_is_iter(aluop_t op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_div(aluop_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(aluop_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative engine: unsigned shift-add multiply / restoring divide on operand
// magnitudes, one bit per step. Sign fix-up is left to the caller.
module seq_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   prod,
    output logic [WIDTH-1:0]     quo,
    output logic [WIDTH-1:0]     rem,
    output logic                 neg_res,
    output logic                 neg_rem
);

    localparam int CNTW = $clog2(WIDTH) + 1;

    logic [CNTW-1:0]  cnt;
    logic             div_mode;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] opd;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] sh_d;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    always_comb begin
        sum     = {1'b0, acc} + (sh[0] ? {1'b0, opd} : '0);
        shifted = {acc, sh[WIDTH-1]};
        diff    = shifted - {1'b0, opd};
        acc_d   = acc;
        sh_d    = sh;
        if (div_mode) begin
            // A clear borrow bit means the trial subtraction fits: keep it and emit a 1.
            if (!diff[WIDTH]) begin
                acc_d = diff[WIDTH-1:0];
                sh_d  = {sh[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = shifted[WIDTH-1:0];
                sh_d  = {sh[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = sum[WIDTH:1];
            sh_d  = {sum[0], sh[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            div_mode <= is_div;
            acc      <= '0;
            sh       <= a_mag;
            opd      <= b_mag;
            neg_res  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem  <= is_signed && a[WIDTH-1];
        end else if (step) begin
            acc <= acc_d;
            sh  <= sh_d;
        end
    end

    assign last = (cnt == CNTW'(WIDTH - 1));
    assign prod = {acc, sh};
    assign quo  = sh;
    assign rem  = acc;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle basic ops plus iterative multiply/divide
// writing the HI/LO pair, sequenced by a five-state FSM.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPW-1:0]   aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    aluop_t             op_k;
    logic               load;
    logic               step;
    logic               basic_we;
    logic               fix_we;
    logic               last;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic               neg_res;
    logic               neg_rem;
    logic [WIDTH-1:0]   basic_res;
    logic [WIDTH-1:0]   hi_n;
    logic [WIDTH-1:0]   lo_n;
    logic [WIDTH-1:0]   a_q;
    logic               bz_q;
    logic               isdiv_q;

    function automatic logic [WIDTH-1:0] basic_result(
        input aluop_t           op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] h,
        input logic [WIDTH-1:0] l
    );
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ys;
        xs = signed'(x);
        ys = signed'(y);
        case (op)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_SLT:  return (xs < ys) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
            OP_LUI:  return y << (WIDTH / 2);
            OP_MFHI: return h;
            OP_MFLO: return l;
            default: return y;
        endcase
    endfunction

    // Codes outside the known range collapse to EQB before any decoding.
    assign op_k      = (aluop <= OPW'(OP_MAX)) ? aluop_t'(aluop) : OP_EQB;
    assign basic_res = basic_result(op_k, a, b, hi, lo);

    seq_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .is_div    (op_is_div(op_k)),
        .is_signed (op_is_signed(op_k)),
        .a         (a),
        .b         (b),
        .last      (last),
        .prod      (prod),
        .quo       (quo),
        .rem       (rem),
        .neg_res   (neg_res),
        .neg_rem   (neg_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        step     = 1'b0;
        basic_we = 1'b0;
        fix_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op_is_iter(op_k)) begin
                        load    = 1'b1;
                        state_d = op_is_div(op_k) ? S_DIV : S_MUL;
                    end else begin
                        basic_we = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            S_MUL, S_DIV: begin
                step = 1'b1;
                if (last) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                fix_we  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);

    always_comb begin
        prod_s = neg_res ? -prod : prod;
        hi_n   = prod_s[2*WIDTH-1:WIDTH];
        lo_n   = prod_s[WIDTH-1:0];
        if (isdiv_q) begin
            // Divide by zero bypasses sign correction: quotient all ones, remainder the raw dividend.
            if (bz_q) begin
                lo_n = '1;
                hi_n = a_q;
            end else begin
                lo_n = neg_res ? -quo : quo;
                hi_n = neg_rem ? -rem : rem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            a_q     <= a;
            bz_q    <= (b == '0);
            isdiv_q <= op_is_div(op_k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c    <= '0;
            zero <= 1'b1;
            hi   <= '0;
            lo   <= '0;
            div0 <= 1'b0;
        end else if (basic_we) begin
            c    <= basic_res;
            zero <= (basic_res == '0);
        end else if (fix_we) begin
            hi   <= hi_n;
            lo   <= lo_n;
            c    <= lo_n;
            zero <= (lo_n == '0);
            if (isdiv_q) begin
                div0 <= bz_q;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): basic ops, multiply/divide results
// and latency, ignored start, reset abort.
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  aluop = OP_ADD;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] c;
    logic        zero;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;

    int checks = 0;
    int errors = 0;
    int lat;
    int nbusy;
    int ndone;
    logic [31:0] c_cap;
    logic [31:0] hi_cap;
    logic [31:0] lo_cap;

    seq_alu #(.WIDTH(32), .OPW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .aluop (aluop),
        .a     (a),
        .b     (b),
        .c     (c),
        .zero  (zero),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .div0  (div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench 1 time unit after the start edge; operands are scrambled afterwards.
    task automatic launch(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        aluop = op;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(output int l, output int nb);
        l  = 1;
        nb = 0;
        while (!done && l < 100) begin
            if (busy) nb++;
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_c", c, 0);
        chk("rst_zero", zero, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_div0", div0, 0);

        launch(OP_ADD, 32'd5, -32'sd5);
        wait_done(lat, nbusy);
        chk("add_lat", lat, 1);
        chk("add_busy", nbusy, 0);
        chk("add_c", c, 0);
        chk("add_zero", zero, 1);
        @(posedge clk); #1;
        chk("add_done_pulse", done, 0);

        launch(OP_SLT, -32'sd1, 32'd1);
        wait_done(lat, nbusy);
        chk("slt_c", c, 1);
        chk("slt_zero", zero, 0);

        launch(OP_SUB, 32'd10, 32'd3);
        wait_done(lat, nbusy);
        chk("sub_c", c, 7);

        launch(OP_AND, 32'h0000F0F0, 32'h0000FF00);
        wait_done(lat, nbusy);
        chk("and_c", c, 32'h0000F000);

        launch(OP_OR, 32'h0000F0F0, 32'h0000FF00);
        wait_done(lat, nbusy);
        chk("or_c", c, 32'h0000FFF0);

        launch(OP_LUI, 32'h0, 32'h00001234);
        wait_done(lat, nbusy);
        chk("lui_c", c, 32'h12340000);

        launch(4'hF, 32'h1, 32'hDEADBEEF);
        wait_done(lat, nbusy);
        chk("unk_c", c, 32'hDEADBEEF);
        chk("basic_hi_kept", hi, 0);
        chk("basic_lo_kept", lo, 0);

        launch(OP_MULT, -32'sd3, 32'd7);
        wait_done(lat, nbusy);
        chk("mult_lat", lat, 34);
        chk("mult_busy", nbusy, 33);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);
        chk("mult_c", c, 32'hFFFFFFEB);
        chk("mult_zero", zero, 0);
        @(posedge clk); #1;
        chk("mult_done_pulse", done, 0);

        launch(OP_MFHI, 32'h0, 32'h0);
        wait_done(lat, nbusy);
        chk("mfhi_c", c, 32'hFFFFFFFF);
        chk("mfhi_lo_kept", lo, 32'hFFFFFFEB);

        launch(OP_MFLO, 32'h0, 32'h0);
        wait_done(lat, nbusy);
        chk("mflo_c", c, 32'hFFFFFFEB);

        launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, nbusy);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);

        launch(OP_DIV, -32'sd7, 32'd2);
        wait_done(lat, nbusy);
        chk("div_lat", lat, 34);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        chk("div_div0", div0, 0);

        launch(OP_DIVU, 32'd7, 32'd0);
        wait_done(lat, nbusy);
        chk("div0_lat", lat, 34);
        chk("div0_lo", lo, 32'hFFFFFFFF);
        chk("div0_hi", hi, 7);
        chk("div0_flag", div0, 1);

        launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat, nbusy);
        chk("minneg_lo", lo, 32'h80000000);
        chk("minneg_hi", hi, 0);
        chk("minneg_div0", div0, 0);

        launch(OP_DIVU, 32'd100, 32'd7);
        wait_done(lat, nbusy);
        chk("divu_lo", lo, 14);
        chk("divu_hi", hi, 2);

        // ADD start pulsed five cycles into a MULT must be ignored.
        launch(OP_MULT, 32'd1000, -32'sd2);
        ndone = 0;
        lat   = 0;
        for (int k = 1; k <= 50; k++) begin
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat    = k;
                    c_cap  = c;
                    hi_cap = hi;
                    lo_cap = lo;
                end
            end
            @(negedge clk);
            start = (k == 5);
            aluop = OP_ADD;
            a     = 32'd1;
            b     = 32'd1;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk("ign_ndone", ndone, 1);
        chk("ign_lat", lat, 34);
        chk("ign_c", c_cap, 32'hFFFFF830);
        chk("ign_hi", hi_cap, 32'hFFFFFFFF);
        chk("ign_lo", lo_cap, 32'hFFFFF830);
        chk("ign_c_after", c, 32'hFFFFF830);

        // Reset at iteration 10 of a divide aborts it.
        launch(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_c", c, 0);
        chk("abort_zero", zero, 1);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) ndone++;
            @(posedge clk);
            #1;
        end
        chk("abort_no_done", ndone, 0);

        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        aluop = OP_ADD;
        a     = 32'd5;
        b     = 32'd6;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_done", done, 0);
        chk("rst_start_c", c, 0);

        launch(OP_DIVU, 32'd1000, 32'd3);
        wait_done(lat, nbusy);
        chk("restart_lat", lat, 34);
        chk("restart_lo", lo, 333);
        chk("restart_hi", hi, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
